bop_round_ctrl: RTL and testbench

BOP_ROUND_CTRL -- requirements
Module: bop_round_ctrl

---
 rtl/bop_round_ctrl_pkg.sv | 66 ++++++
 rtl/bop_round_ctrl_if.sv | 30 +++
 rtl/bop_round_ctrl_bcd2_counter.sv | 23 ++
 rtl/bop_round_ctrl.sv | 169 ++++++++++++++++
 tb/tb_bop_round_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bop_round_ctrl_pkg.sv
// Shared types and helpers for the bop-it round controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, command codes, sound request codes,
//           BCD increment / integer-to-BCD / modulo-12 helpers.
package bopit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WIN   = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Command codes: one per physical input; the code is also the bit index
  // of that input in the 12-bit action vector {btn, sw}.
  localparam logic [3:0] CMD_SW0  = 4'd0;
  localparam logic [3:0] CMD_SW1  = 4'd1;
  localparam logic [3:0] CMD_SW2  = 4'd2;
  localparam logic [3:0] CMD_SW3  = 4'd3;
  localparam logic [3:0] CMD_SW4  = 4'd4;
  localparam logic [3:0] CMD_SW5  = 4'd5;
  localparam logic [3:0] CMD_SW6  = 4'd6;
  localparam logic [3:0] CMD_SW7  = 4'd7;
  localparam logic [3:0] CMD_BTNU = 4'd8;
  localparam logic [3:0] CMD_BTNR = 4'd9;
  localparam logic [3:0] CMD_BTND = 4'd10;
  localparam logic [3:0] CMD_BTNL = 4'd11;

  localparam int NUM_CMDS = 12;

  localparam logic [1:0] SND_OFF  = 2'd0;
  localparam logic [1:0] SND_WIN  = 2'd1;
  localparam logic [1:0] SND_FAIL = 2'd2;

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = v[3:0];
    hi = v[7:4];
    if (lo >= 4'd9) begin
      lo = 4'd0;
      hi = (hi >= 4'd9) ? 4'd0 : hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  // Elaboration-time conversion of a 0..99 integer to two BCD digits.
  function automatic logic [7:0] int_to_bcd(input int v);
    return {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // rnd is at most 31, so two conditional subtractions cover mod 12.
  function automatic logic [3:0] mod12(input logic [4:0] r);
    logic [4:0] t;
    if (r >= 5'd24)      t = r - 5'd24;
    else if (r >= 5'd12) t = r - 5'd12;
    else                 t = r;
    return t[3:0];
  endfunction

endpackage

// File: rtl/bop_round_ctrl_if.sv
// Player/host-facing bundle of the round controller.
// Latency: n/a (wires only).
// Backpressure: none; all signals are levels or one-cycle strobes.
// Ports: start/tick/rnd/sw/btn flow host->controller; cmd, cmd_valid,
//        timer_bcd, score_bcd, snd_req, game_over flow controller->host.
interface bop_round_ctrl_if;
  logic       start;
  logic       tick;
  logic [4:0] rnd;
  logic [7:0] sw;
  logic [3:0] btn;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic [7:0] timer_bcd;
  logic [7:0] score_bcd;
  logic [1:0] snd_req;
  logic       game_over;

  // Host side drives stimulus and observes the game.
  modport master (
    output start, tick, rnd, sw, btn,
    input  cmd, cmd_valid, timer_bcd, score_bcd, snd_req, game_over
  );

  // Controller side.
  modport slave (
    input  start, tick, rnd, sw, btn,
    output cmd, cmd_valid, timer_bcd, score_bcd, snd_req, game_over
  );
endinterface

// File: rtl/bop_round_ctrl_bcd2_counter.sv
// Two-digit BCD counter with clear and increment, wrapping 99 -> 00.
// Latency: value updates one clock after clr/inc.
// Backpressure: none; clr has priority over inc.
// Ports: clk, rst (sync, active-high), clr, inc, value[7:0].
module bcd2_counter
  import bopit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] value
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= 8'h00;
    end else if (inc) begin
      value <= bcd_inc(value);
    end
  end

endmodule

// File: rtl/bop_round_ctrl.sv
// Bop-it round controller: issues a random command, times the response,
// scores wins and signals game over.
// Latency: input edge -> WIN/OVER two clocks (input register + edge detect).
// Backpressure: none; inputs are sampled every cycle, nothing is stalled.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries
//        start/tick/rnd/sw/btn in and cmd/cmd_valid/timer/score/snd/game_over out.
module bop_round_ctrl
  import bopit_pkg::*;
#(
  parameter int TIMEOUT_S      = 10,
  parameter int WIN_DELAY      = 3,
  parameter int FAIL_SND_TICKS = 1
) (
  input  logic            clk,
  input  logic            rst,
  bop_round_ctrl_if.slave bus
);

  localparam logic [7:0] TIMEOUT_BCD = int_to_bcd(TIMEOUT_S);
  localparam logic [3:0] WIN_LAST    = 4'(WIN_DELAY - 1);
  localparam logic [3:0] FAIL_LAST   = 4'(FAIL_SND_TICKS - 1);

  state_t     state;
  logic [3:0] cmd_r;
  logic       cmd_valid_r;
  logic [1:0] snd_r;
  logic       game_over_r;
  logic [3:0] tick_cnt;

  logic [7:0] sw_q, sw_prev;
  logic [3:0] btn_q, btn_prev;

  // The input registers load the live levels during reset so that anything
  // already held high at release looks like a steady level, not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q     <= bus.sw;
      sw_prev  <= bus.sw;
      btn_q    <= bus.btn;
      btn_prev <= bus.btn;
    end else begin
      sw_q     <= bus.sw;
      sw_prev  <= sw_q;
      btn_q    <= bus.btn;
      btn_prev <= btn_q;
    end
  end

  // Action vector bit n corresponds to command code n.
  logic [NUM_CMDS-1:0] act;
  logic [NUM_CMDS-1:0] target;
  logic                act_any;
  logic                act_hit;

  assign act     = {btn_q & ~btn_prev, sw_q & ~sw_prev};
  assign target  = 12'd1 << cmd_r;
  assign act_any = |act;
  assign act_hit = (act == target);

  // Counter controls. start clears everything; an action in WAIT takes
  // precedence over a coincident tick, so the timer does not advance then.
  logic [7:0] timer_bcd;
  logic [7:0] score_bcd;
  logic       timer_clr, timer_inc, timeout;
  logic       score_clr, score_inc;

  assign timer_clr = bus.start || (state == ST_ISSUE);
  assign timer_inc = (state == ST_WAIT) && bus.tick && !act_any && !bus.start;
  assign timeout   = (bcd_inc(timer_bcd) == TIMEOUT_BCD);
  assign score_clr = bus.start;
  assign score_inc = (state == ST_WIN) && bus.tick && !bus.start
                     && (tick_cnt == WIN_LAST);

  bcd2_counter u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .inc   (timer_inc),
    .value (timer_bcd)
  );

  bcd2_counter u_score (
    .clk   (clk),
    .rst   (rst),
    .clr   (score_clr),
    .inc   (score_inc),
    .value (score_bcd)
  );

  // tick_cnt counts ticks spent in WIN (towards the next command) or in
  // OVER (towards silencing the fail tone); it is zeroed on entry to both.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cmd_r       <= CMD_SW0;
      cmd_valid_r <= 1'b0;
      snd_r       <= SND_OFF;
      game_over_r <= 1'b0;
      tick_cnt    <= 4'd0;
    end else if (bus.start) begin
      state       <= ST_ISSUE;
      cmd_valid_r <= 1'b0;
      snd_r       <= SND_OFF;
      game_over_r <= 1'b0;
      tick_cnt    <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
        end
        ST_ISSUE: begin
          cmd_r       <= mod12(bus.rnd);
          cmd_valid_r <= 1'b1;
          snd_r       <= SND_OFF;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          if (act_any) begin
            cmd_valid_r <= 1'b0;
            tick_cnt    <= 4'd0;
            if (act_hit) begin
              state <= ST_WIN;
              snd_r <= SND_WIN;
            end else begin
              state       <= ST_OVER;
              snd_r       <= SND_FAIL;
              game_over_r <= 1'b1;
            end
          end else if (bus.tick && timeout) begin
            cmd_valid_r <= 1'b0;
            tick_cnt    <= 4'd0;
            state       <= ST_OVER;
            snd_r       <= SND_FAIL;
            game_over_r <= 1'b1;
          end
        end
        ST_WIN: begin
          if (bus.tick) begin
            snd_r <= SND_OFF;
            if (tick_cnt == WIN_LAST) begin
              tick_cnt <= 4'd0;
              state    <= ST_ISSUE;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        ST_OVER: begin
          // Count only while the tone is still on; after that OVER is static.
          if (bus.tick && (snd_r == SND_FAIL)) begin
            if (tick_cnt == FAIL_LAST) begin
              snd_r <= SND_OFF;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd       = cmd_r;
  assign bus.cmd_valid = cmd_valid_r;
  assign bus.timer_bcd = timer_bcd;
  assign bus.score_bcd = score_bcd;
  assign bus.snd_req   = snd_r;
  assign bus.game_over = game_over_r;

endmodule

// File: tb/tb_bop_round_ctrl.sv
// Self-checking bench for bop_round_ctrl: directed scenarios plus random
// rounds, checked against a score/timer/command model kept as plain integers.
module tb_bop_round_ctrl;

  localparam int TIMEOUT_S      = 10;
  localparam int WIN_DELAY      = 3;
  localparam int FAIL_SND_TICKS = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bop_round_ctrl_if bus ();

  bop_round_ctrl #(
    .TIMEOUT_S      (TIMEOUT_S),
    .WIN_DELAY      (WIN_DELAY),
    .FAIL_SND_TICKS (FAIL_SND_TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: game quantities as plain integers.
  int m_score;
  int m_timer;
  int m_cmd;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic release_inputs();
    bus.sw  = 8'h00;
    bus.btn = 4'h0;
  endtask

  // Start a game with the given random value; ends with the command in WAIT.
  task automatic do_start(input logic [4:0] r);
    bus.start = 1'b1;
    bus.rnd   = r;
    step();
    bus.start = 1'b0;
    chk("start_vld",   bus.cmd_valid, 0);
    chk("start_score", bus.score_bcd, 0);
    chk("start_snd",   bus.snd_req,   0);
    chk("start_over",  bus.game_over, 0);
    step();
    m_cmd   = int'(r) % 12;
    m_timer = 0;
    m_score = 0;
    chk("issue_cmd",   bus.cmd,       m_cmd);
    chk("issue_vld",   bus.cmd_valid, 1);
    chk("issue_timer", bus.timer_bcd, 0);
  endtask

  // n ticks in WAIT with no action; the timer advances each tick.
  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do_tick();
      m_timer++;
      chk("timer_step", bus.timer_bcd, to_bcd(m_timer));
      if (m_timer == TIMEOUT_S) begin
        chk("timeout_over", bus.game_over, 1);
        chk("timeout_snd",  bus.snd_req,   2);
        chk("timeout_vld",  bus.cmd_valid, 0);
      end else begin
        chk("wait_over", bus.game_over, 0);
        chk("wait_vld",  bus.cmd_valid, 1);
      end
    end
  endtask

  // Raise the inputs in mask; the FSM reacts two clocks later. with_tick
  // puts a tick in the very cycle the edge is evaluated.
  task automatic rise(input logic [11:0] mask, input logic with_tick);
    bus.sw  = mask[7:0];
    bus.btn = mask[11:8];
    step();
    bus.tick = with_tick;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic win_round(input logic [4:0] next_r, input logic with_tick);
    logic [11:0] m;
    m = 12'd1 << m_cmd;
    rise(m, with_tick);
    release_inputs();
    chk("win_snd",   bus.snd_req,   1);
    chk("win_vld",   bus.cmd_valid, 0);
    chk("win_over",  bus.game_over, 0);
    chk("win_timer", bus.timer_bcd, to_bcd(m_timer));
    for (int i = 0; i < WIN_DELAY; i++) begin
      if (i == WIN_DELAY - 1) bus.rnd = next_r;
      do_tick();
      chk("win_snd_off", bus.snd_req, 0);
      if (i < WIN_DELAY - 1) chk("win_score_hold", bus.score_bcd, to_bcd(m_score));
    end
    m_score = (m_score + 1) % 100;
    chk("win_score", bus.score_bcd, to_bcd(m_score));
    step();
    m_cmd   = int'(next_r) % 12;
    m_timer = 0;
    chk("next_cmd",   bus.cmd,       m_cmd);
    chk("next_vld",   bus.cmd_valid, 1);
    chk("next_timer", bus.timer_bcd, 0);
  endtask

  task automatic lose_round(input logic [11:0] mask, input logic with_tick);
    rise(mask, with_tick);
    release_inputs();
    chk("lose_over",  bus.game_over, 1);
    chk("lose_snd",   bus.snd_req,   2);
    chk("lose_vld",   bus.cmd_valid, 0);
    chk("lose_timer", bus.timer_bcd, to_bcd(m_timer));
    chk("lose_score", bus.score_bcd, to_bcd(m_score));
    step();
    step();
    for (int i = 0; i < FAIL_SND_TICKS; i++) begin
      chk("fail_tone_on", bus.snd_req, 2);
      do_tick();
    end
    chk("fail_tone_off", bus.snd_req, 0);
    do_tick();
    do_tick();
    chk("over_persist", bus.game_over, 1);
    chk("over_timer",   bus.timer_bcd, to_bcd(m_timer));
    chk("over_score",   bus.score_bcd, to_bcd(m_score));
  endtask

  function automatic logic [11:0] wrong_bit(input int tgt);
    int o;
    o = (tgt + 1 + int'($urandom_range(0, 10))) % 12;
    return 12'd1 << o;
  endfunction

  function automatic logic [4:0] rnd5();
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    bus.start = 1'b0;
    bus.tick  = 1'b0;
    bus.rnd   = 5'd0;
    bus.sw    = 8'h08;   // sw[3] held through reset
    bus.btn   = 4'h0;
    rst       = 1'b1;
    m_score   = 0;
    m_timer   = 0;
    m_cmd     = 0;
    repeat (3) step();
    chk("rst_cmd",   bus.cmd,       0);
    chk("rst_vld",   bus.cmd_valid, 0);
    chk("rst_timer", bus.timer_bcd, 0);
    chk("rst_score", bus.score_bcd, 0);
    chk("rst_snd",   bus.snd_req,   0);
    chk("rst_over",  bus.game_over, 0);
    rst = 1'b0;
    repeat (3) step();
    chk("idle_vld", bus.cmd_valid, 0);
    chk("idle_cmd", bus.cmd,       0);

    // Held sw[3] must not count until it falls and rises again.
    do_start(5'd3);
    repeat (4) step();
    chk("held_vld", bus.cmd_valid, 1);
    chk("held_snd", bus.snd_req,   0);
    bus.sw = 8'h00;
    step();
    step();
    chk("fall_vld",  bus.cmd_valid, 1);
    chk("fall_over", bus.game_over, 0);
    win_round(5'd17, 1'b0);

    // rnd 17 -> switch 5; win and score 01, then rnd 21 -> button R.
    do_start(5'd17);
    win_round(5'd21, 1'b0);
    // btn U while R is requested.
    lose_round(12'h100, 1'b0);

    // Timeout after TIMEOUT_S ticks.
    do_start(rnd5());
    idle_ticks(TIMEOUT_S);
    chk("to_snd_on", bus.snd_req, 2);
    do_tick();
    chk("to_snd_off", bus.snd_req,   0);
    chk("to_frozen",  bus.timer_bcd, to_bcd(m_timer));

    // Correct + wrong edge together -> OVER.
    do_start(rnd5());
    idle_ticks(int'($urandom_range(0, 5)));
    lose_round((12'd1 << m_cmd) | wrong_bit(m_cmd), 1'b0);
    // Wrong edge + tick -> OVER, timer not advanced.
    do_start(rnd5());
    idle_ticks(int'($urandom_range(0, 5)));
    lose_round(wrong_bit(m_cmd), 1'b1);
    // Correct edge + tick -> WIN, timer not advanced (also at 9 seconds).
    do_start(rnd5());
    idle_ticks(int'($urandom_range(0, 5)));
    win_round(rnd5(), 1'b1);
    idle_ticks(TIMEOUT_S - 1);
    win_round(rnd5(), 1'b1);

    // Mid-round start abandons the round silently.
    idle_ticks(3);
    do_start(rnd5());

    // 100 random rounds: score passes 99 and wraps to 00.
    for (int r = 0; r < 100; r++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        step();
        chk("gap_vld", bus.cmd_valid, 1);
      end
      idle_ticks(int'($urandom_range(0, TIMEOUT_S - 1)));
      win_round(rnd5(), 1'($urandom_range(0, 1)));
    end
    chk("score_wrap", bus.score_bcd, 8'h00);

    // Start while in WIN clears the score and re-issues.
    win_round(rnd5(), 1'b0);
    win_round(rnd5(), 1'b0);
    chk("pre_start_score", bus.score_bcd, to_bcd(m_score));
    rise(12'd1 << m_cmd, 1'b0);
    release_inputs();
    chk("win_before_start", bus.snd_req, 1);
    do_start(rnd5());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
